vga_scanout: RTL
================

# vga_scanout

Framebuffer reader and VGA timing generator for the 160x120, 3-bit-colour display path. The drawing FSMs write pixels into a dual-port framebuffer RAM. This block is the read side of that RAM. It scans the RAM in raster order, upscales each stored pixel 4x4 onto a 640x480@60 Hz raster, and drives the board VGA DAC pins and sync. It also emits a once-per-frame vertical-blank pulse that game logic uses as its animation tick, in place of free-running slow counters.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- Clock, input, 1, 50 MHz system clock. This is the only clock.
- Reset, input, 1, asynchronous, active-high reset.
- rd_addr, output, 15, framebuffer read address: y*160 + x.
- rd_data, input, 3, framebuffer colour {R,G,B}. Valid one Clock after rd_addr.
- VGA_R, output, 8, red channel: {8{colour[2]}}.
- VGA_G, output, 8, green channel: {8{colour[1]}}.
- VGA_B, output, 8, blue channel: {8{colour[0]}}.
- VGA_HS, output, 1, horizontal sync, active low.
- VGA_VS, output, 1, vertical sync, active low.
- VGA_BLANK_N, output, 1, high in the visible region.
- VGA_SYNC_N, output, 1, constant 0.
- VGA_CLK, output, 1, 25 MHz pixel clock to the DAC. Equal to pix_en.
- vblank_start, output, 1, one-Clock pulse per frame.

## Operation
- pix_en: a register that toggles every Clock. All pixel-rate logic advances only on edges where pix_en==1, so the pixel rate is 25 MHz.
- h counter:
  - Range 0..799 (H_VIS+H_FP+H_SYNC+H_BP-1), width 10.
  - Increments when pix_en==1.
  - Wraps from 799 to 0.
- v counter:
  - Range 0..524, width 10.
  - Increments when pix_en==1 and h==799.
  - Wraps from 524 to 0.
- Visible region: vis = (h<640)&&(v<480).
- Address generation:
  - x = h[9:2], y = v[9:2].
  - rd_addr = (y<<7)+(y<<5)+x. This is combinational from the registered counters.
  - rd_addr = 0 when !vis.
  - Maximum value is 19199 at h=639, v=479.
- Output registers load on edges where pix_en==1, using the current (pre-increment) h, v and rd_data:
  - colour = vis ? rd_data : 3'b000
  - VGA_BLANK_N = vis
  - VGA_HS = !(656<=h<=751)
  - VGA_VS = !(490<=v<=491)
- Data validity: the counters change on a pix_en==1 edge, and the RAM samples the new rd_addr on the following edge. rd_data is therefore stable at the next pix_en==1 edge, and no extra pipeline stage is needed.
- The sync, blank and colour outputs all pass through the same register stage. They stay mutually aligned and lag the counters by one pixel (2 Clocks).
- vblank_start:
  - Registered.
  - High for exactly one Clock, in the cycle after the edge where the counters advance from (h=799, v=479) to (h=0, v=480).

## Timing
- Reset values (asynchronous, immediate):
  - pix_en=0, h=0, v=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0
  - colour=0, so VGA_R, VGA_G and VGA_B are all 0
  - vblank_start=0
- Reset released mid-frame: the raster restarts at h=0, v=0. No partial-frame state is retained.
- First pix_en==1 edge after reset: pix_en is 0 in the first cycle after reset, so the first such edge is the second rising edge. Outputs then reflect h=0, v=0: BLANK_N=1 and colour = rd_data at address 0.
- VGA_CLK rising edge: occurs one Clock after the outputs update, i.e. mid-pixel.
- Periods:
  - Line: 1600 Clocks.
  - Frame: 840000 Clocks.
  - HS low: 192 Clocks per line.
  - VS low: 3200 Clocks per frame.
- Each framebuffer address is held for 8 consecutive Clocks (4 pixels) within a line, and repeats on 4 consecutive lines.

## Test plan
- Reset:
  - Stimulus: assert Reset asynchronously mid-line (h≈300, v≈200), hold 3 Clocks, release.
  - Required: outputs take their reset values immediately; the first visible pixel after release is at h=0, v=0; HS and VS are high; BLANK_N goes to 1 on the first pix_en edge.
- Horizontal timing:
  - Stimulus: run 2 lines.
  - Required: VGA_HS falls 2*657 Clocks after the line start and stays low for 192 Clocks; VGA_BLANK_N stays high for 1280 Clocks per line; line period is 1600 Clocks.
- Vertical timing:
  - Stimulus: run 1 full frame.
  - Required: VGA_VS is low for 3200 Clocks, starting at line 490; vblank_start pulses exactly once, for 1 Clock; frame period is 840000 Clocks.
- Address mapping (with a RAM model returning addr[2:0]):
  - h=40, v=12: rd_addr=490.
  - h=639, v=479: rd_addr=19199.
  - h=700: rd_addr=0.
  - rd_addr holds each value for 8 Clocks.
- Colour path:
  - Stimulus: fill the RAM model with address 5 = 3'b101 and all other addresses = 0.
  - Required: VGA_R=8'hFF, VGA_G=0, VGA_B=8'hFF for exactly 4 pixels on lines 0–3 at h=20..23 (displayed one pixel later); all blanked pixels are black.
- Continuous run:
  - Stimulus: run 3 frames.
  - Required: VGA_SYNC_N stays 0; VGA_CLK toggles every Clock; no X on any output after reset.

Source files
------------

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer reader and 640x480@60 VGA timing, 4x4 upscale of 160x120
`timescale 1ns/1ps

module vga_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        vblank_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] V_VIS_M1 = 10'(V_VIS - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic       pix_en;
  logic [9:0] h;
  logic [9:0] v;
  logic [2:0] colour;
  logic       vis;
  logic [7:0] x;
  logic [7:0] y;

  assign vis = (h < H_VIS_L) && (v < V_VIS_L);
  assign x   = h[9:2];
  assign y   = v[9:2];

  // y*160 as two shifts; the RAM registers this address on the non-pixel edge
  assign rd_addr = vis ? ({y, 7'b0} + {2'b0, y, 5'b0} + {7'b0, x}) : 15'd0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pix_en       <= 1'b0;
      h            <= '0;
      v            <= '0;
      colour       <= 3'b000;
      VGA_BLANK_N  <= 1'b0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      vblank_start <= 1'b0;
    end else begin
      pix_en       <= ~pix_en;
      vblank_start <= pix_en && (h == H_LAST) && (v == V_VIS_M1);
      if (pix_en) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
        // outputs use pre-increment counters, so they lag the raster by one pixel
        colour      <= vis ? rd_data : 3'b000;
        VGA_BLANK_N <= vis;
        VGA_HS      <= !((h >= HS_FIRST) && (h <= HS_LAST));
        VGA_VS      <= !((v >= VS_FIRST) && (v <= VS_LAST));
      end
    end
  end

  assign VGA_R      = {8{colour[2]}};
  assign VGA_G      = {8{colour[1]}};
  assign VGA_B      = {8{colour[0]}};
  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = pix_en;

endmodule
